pipe_ctrl: RTL and testbench

Pipeline hazard and redirect controller for the RV32 core. Sits between EX/ID and the fetch stage, driving the fetch stage's `hold`, `nop`, `jmp_vld` and `jmp_addr` inputs and the ID/EX stage hold and flush controls. Arbitrates among traps, taken branches/jumps, multi-cycle execute stalls and load-use hazards with a fixed priority. Keeps 32-bit redirect and stall counters for performance monitoring.

---
 rtl/pipe_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: trap > jump > busy > load-use arbitration, perf counters.
// Latency: control outputs are combinational from inputs and state; state and counters update on the next edge.
// Backpressure: holds freeze fetch/ID/EX while a multi-cycle EX op or load-use bubble is pending.
module pipe_ctrl #(
    parameter int REDIR_MASK = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trap_vld,
    input  logic [31:0]      trap_addr,
    input  logic             ex_jmp_vld,
    input  logic [31:0]      ex_jmp_addr,
    input  logic             ex_busy,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_use,
    input  logic             id_rs2_use,
    output logic             if_hold,
    output logic             if_nop,
    output logic             jmp_vld,
    output logic [31:0]      jmp_addr,
    output logic             id_hold,
    output logic             id_flush,
    output logic             ex_hold,
    output logic             ex_flush,
    output logic [CNT_W-1:0] redir_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, LDSTALL, BUSY, REDIR} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [1:0] mask_cnt;
    logic       ld_hazard;
    logic       ex_ok;

    assign ld_hazard = ex_is_load && (ex_rd != 5'd0) &&
                       ((id_rs1_use && (id_rs1 == ex_rd)) ||
                        (id_rs2_use && (id_rs2 == ex_rd)));

    // EX-sourced requests are masked for a few cycles after any redirect.
    assign ex_ok = (state != REDIR);

    always_comb begin
        if_hold  = 1'b0;
        if_nop   = 1'b0;
        jmp_vld  = 1'b0;
        jmp_addr = 32'd0;
        id_hold  = 1'b0;
        id_flush = 1'b0;
        ex_hold  = 1'b0;
        ex_flush = 1'b0;
        if (!rst) begin
            if (trap_vld) begin
                jmp_vld  = 1'b1;
                jmp_addr = trap_addr;
                if_nop   = 1'b1;
                id_flush = 1'b1;
                ex_flush = 1'b1;
            end else if (ex_ok && ex_jmp_vld) begin
                jmp_vld  = 1'b1;
                jmp_addr = ex_jmp_addr;
                if_nop   = 1'b1;
                id_flush = 1'b1;
            end else if (ex_ok && ex_busy) begin
                if_hold = 1'b1;
                id_hold = 1'b1;
                ex_hold = 1'b1;
            end else if ((state == RUN) && ld_hazard) begin
                if_hold  = 1'b1;
                id_hold  = 1'b1;
                id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            mask_cnt  <= 2'd0;
            redir_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (jmp_vld)
                redir_cnt <= redir_cnt + CNT_ONE;
            if (if_hold)
                stall_cnt <= stall_cnt + CNT_ONE;

            if (jmp_vld) begin
                state    <= REDIR;
                mask_cnt <= 2'(REDIR_MASK);
            end else if (state == REDIR) begin
                mask_cnt <= mask_cnt - 2'd1;
                if (mask_cnt <= 2'd1)
                    state <= RUN;
            end else if (ex_hold) begin
                state <= BUSY;
            end else if (id_flush) begin
                // Only a load-use bubble flushes ID without a redirect.
                state <= LDSTALL;
            end else begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic against a flag-based behavioural model.
// A second instance with 4-bit counters shares the stimulus to exercise counter wrap.
module tb_pipe_ctrl;

    localparam int MASK = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_vld, ex_jmp_vld, ex_busy, ex_is_load, id_rs1_use, id_rs2_use;
    logic [31:0] trap_addr, ex_jmp_addr;
    logic [4:0]  ex_rd, id_rs1, id_rs2;

    logic        if_hold, if_nop, jmp_vld, id_hold, id_flush, ex_hold, ex_flush;
    logic [31:0] jmp_addr, redir_cnt, stall_cnt;
    logic        w_if_hold, w_if_nop, w_jmp_vld, w_id_hold, w_id_flush, w_ex_hold, w_ex_flush;
    logic [31:0] w_jmp_addr;
    logic [3:0]  w_redir_cnt, w_stall_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: remaining masked cycles, hazard-mask flag, counters.
    int          m_redir_left;
    bit          m_mask_hz;
    logic [31:0] m_redir_cnt, m_stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.REDIR_MASK(MASK), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .trap_vld(trap_vld), .trap_addr(trap_addr),
        .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr),
        .ex_busy(ex_busy), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
        .if_hold(if_hold), .if_nop(if_nop), .jmp_vld(jmp_vld), .jmp_addr(jmp_addr),
        .id_hold(id_hold), .id_flush(id_flush), .ex_hold(ex_hold), .ex_flush(ex_flush),
        .redir_cnt(redir_cnt), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.REDIR_MASK(MASK), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .trap_vld(trap_vld), .trap_addr(trap_addr),
        .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr),
        .ex_busy(ex_busy), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
        .if_hold(w_if_hold), .if_nop(w_if_nop), .jmp_vld(w_jmp_vld), .jmp_addr(w_jmp_addr),
        .id_hold(w_id_hold), .id_flush(w_id_flush), .ex_hold(w_ex_hold), .ex_flush(w_ex_flush),
        .redir_cnt(w_redir_cnt), .stall_cnt(w_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        trap_vld = 0; trap_addr = 0; ex_jmp_vld = 0; ex_jmp_addr = 0;
        ex_busy = 0; ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_use = 0; id_rs2_use = 0;
    endtask

    // Called just after a falling edge with inputs applied; checks, clocks, returns at next falling edge.
    task automatic cyc();
        bit tr, jp, bz, hz, ld;
        logic [31:0] e_addr;
        bit masked;
        masked = (m_redir_left > 0);
        tr = !rst && trap_vld;
        jp = !rst && !tr && ex_jmp_vld && !masked;
        bz = !rst && !tr && !jp && ex_busy && !masked;
        hz = ex_is_load && (ex_rd != 0) &&
             ((id_rs1_use && id_rs1 == ex_rd) || (id_rs2_use && id_rs2 == ex_rd));
        ld = !rst && !tr && !jp && !bz && !masked && !m_mask_hz && hz;
        e_addr = tr ? trap_addr : (jp ? ex_jmp_addr : 32'd0);
        #1;
        chk("jmp_vld",   {31'd0, jmp_vld},  {31'd0, tr || jp});
        chk("jmp_addr",  jmp_addr,          e_addr);
        chk("if_nop",    {31'd0, if_nop},   {31'd0, tr || jp});
        chk("if_hold",   {31'd0, if_hold},  {31'd0, bz || ld});
        chk("id_hold",   {31'd0, id_hold},  {31'd0, bz || ld});
        chk("id_flush",  {31'd0, id_flush}, {31'd0, tr || jp || ld});
        chk("ex_hold",   {31'd0, ex_hold},  {31'd0, bz});
        chk("ex_flush",  {31'd0, ex_flush}, {31'd0, tr});
        chk("redir_cnt", redir_cnt,         m_redir_cnt);
        chk("stall_cnt", stall_cnt,         m_stall_cnt);
        chk("w_jmp_vld", {31'd0, w_jmp_vld}, {31'd0, tr || jp});
        chk("w_if_hold", {31'd0, w_if_hold}, {31'd0, bz || ld});
        chk("w_redir_cnt", {28'd0, w_redir_cnt}, m_redir_cnt % 16);
        chk("w_stall_cnt", {28'd0, w_stall_cnt}, m_stall_cnt % 16);
        @(posedge clk);
        if (rst) begin
            m_redir_left = 0; m_mask_hz = 0; m_redir_cnt = 0; m_stall_cnt = 0;
        end else begin
            if (tr || jp) m_redir_cnt = m_redir_cnt + 1;
            if (bz || ld) m_stall_cnt = m_stall_cnt + 1;
            if (tr || jp)          m_redir_left = MASK;
            else if (masked)       m_redir_left = m_redir_left - 1;
            m_mask_hz = bz || ld;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1; cyc(); rst = 0;
    endtask

    initial begin
        m_redir_left = 0; m_mask_hz = 0; m_redir_cnt = 0; m_stall_cnt = 0;
        idle();
        rst = 1;
        @(negedge clk);

        // Reset: outputs forced low even with a trap request present.
        trap_vld = 1; trap_addr = 32'h44; ex_busy = 1;
        cyc();
        chk("rst_jmp_vld", {31'd0, jmp_vld}, 32'd0);
        cyc();
        chk("rst_redir_cnt", redir_cnt, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        rst = 0;

        // Load-use: one bubble, then the hazard is re-checked in RUN.
        idle(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_use = 1;
        cyc();
        chk("ldu_stall_cnt", stall_cnt, 32'd1);
        cyc();
        chk("ldu_one_bubble", stall_cnt, 32'd1);
        ex_rd = 0; id_rs1 = 0;
        cyc();
        chk("ldu_rd0", stall_cnt, 32'd1);
        ex_rd = 7; id_rs2 = 7; id_rs2_use = 1; id_rs1_use = 0;
        cyc();
        chk("ldu_rs2", stall_cnt, 32'd2);

        // Taken jump, then a masked jump the next cycle.
        do_reset();
        ex_jmp_vld = 1; ex_jmp_addr = 32'h100;
        cyc();
        ex_jmp_addr = 32'h104;
        cyc();
        chk("jmp_redir_cnt", redir_cnt, 32'd1);
        ex_jmp_vld = 0;
        cyc();

        // Busy for five cycles.
        do_reset();
        ex_busy = 1;
        repeat (5) cyc();
        ex_busy = 0;
        cyc();
        chk("busy_stall_cnt", stall_cnt, 32'd5);

        // Trap beats jump, and a trap during REDIR is taken.
        do_reset();
        trap_vld = 1; trap_addr = 32'h80; ex_jmp_vld = 1; ex_jmp_addr = 32'h200;
        cyc();
        trap_addr = 32'h90;
        cyc();
        chk("trap_redir_cnt", redir_cnt, 32'd2);
        idle();
        cyc();

        // Reset in the middle of BUSY.
        do_reset();
        ex_busy = 1;
        repeat (2) cyc();
        rst = 1;
        repeat (2) cyc();
        chk("rstbusy_stall_cnt", stall_cnt, 32'd0);
        rst = 0; ex_busy = 0;
        cyc();
        chk("rstbusy_no_hold", stall_cnt, 32'd0);

        // Counter wrap on the 4-bit instance.
        do_reset();
        ex_busy = 1;
        repeat (17) cyc();
        ex_busy = 0;
        cyc();
        chk("wrap_w_stall", {28'd0, w_stall_cnt}, 32'd1);
        chk("wrap_stall", stall_cnt, 32'd17);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            trap_vld    = ($urandom_range(0, 19) == 0);
            trap_addr   = $urandom;
            ex_jmp_vld  = ($urandom_range(0, 7) == 0);
            ex_jmp_addr = $urandom;
            ex_busy     = ($urandom_range(0, 3) == 0);
            ex_is_load  = $urandom_range(0, 1);
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rs1_use  = $urandom_range(0, 1);
            id_rs2_use  = $urandom_range(0, 1);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
